rr_stream_mux: RTL and testbench

- Parametrised N-channel stream multiplexer. The select input is replaced by a round-robin arbiter, and each channel has a valid/ready handshake.
- Generalises the 4-bit 2:1 and 4:1 muxes to N channels of WIDTH bits, with a registered output and backpressure.
- Merges several producer streams into one consumer stream, for example debug/event channels into a single output FIFO or display path.
- One transfer per cycle is sustained. No channel starves.

---
 rtl/rr_stream_mux_if.sv | 28 ++
 rtl/rr_stream_mux.sv | 77 +++++++
 tb/tb_rr_stream_mux.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rr_stream_mux_if.sv
// Stream bundle for the round-robin mux: N_CH input channels and one output.
// Ports: in_valid/in_data/in_ready per channel, out_valid/out_data/out_ch/out_ready.
interface rr_stream_mux_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;
    logic                  out_ready;

    // Producer/consumer side (drives inputs, observes outputs).
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    // Mux side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel stream mux with round-robin arbitration and a registered output.
// Ports: clk, rst_n (sync, active-low), bus (slave side of rr_stream_mux_if).
module rr_stream_mux #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_stream_mux_if.slave bus
);
    localparam int CH_W = $clog2(N_CH);

    logic [CH_W-1:0]  last_gnt;
    logic [CH_W-1:0]  win;
    logic [N_CH-1:0]  gnt;
    logic             any;
    logic             load;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]  out_ch_q;
    logic [WIDTH-1:0] sel_data;
    int               scan;

    // The output register can take a new word when empty or being drained.
    assign load = !out_valid_q || bus.out_ready;

    // Scan from farthest to nearest so the last hit is the first channel
    // after last_gnt in round-robin order.
    always_comb begin
        win  = last_gnt;
        any  = 1'b0;
        scan = 0;
        for (int k = N_CH; k >= 1; k--) begin
            scan = int'(last_gnt) + k;
            if (scan >= N_CH) scan = scan - N_CH;
            if (bus.in_valid[scan[CH_W-1:0]]) begin
                win = scan[CH_W-1:0];
                any = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (any) gnt[win] = 1'b1;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) sel_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // Gating with rst_n keeps producers from losing words during reset.
    assign bus.in_ready = gnt & {N_CH{load & rst_n}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_gnt    <= CH_W'(N_CH - 1);
        end else if (load) begin
            out_valid_q <= any;
            if (any) begin
                out_data_q <= sel_data;
                out_ch_q   <= win;
                last_gnt   <= win;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed table-driven bench for rr_stream_mux (N_CH=4, WIDTH=4).
// Checks in_ready before each edge and the output register after it.
module tb_rr_stream_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_stream_mux_if #(.N_CH(4), .WIDTH(4)) bus ();

    rr_stream_mux #(.N_CH(4), .WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [15:0] d;
        logic        ordy;
        logic [3:0]  er;
        logic        eov;
        logic [3:0]  eod;
        logic [1:0]  ech;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v,
                       input logic [15:0] d, input logic o,
                       input logic [3:0] er, input logic eov,
                       input logic [3:0] eod, input logic [1:0] ech);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.ordy = o;
        t.er = er; t.eov = eov; t.eod = eod; t.ech = ech;
        vecs.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int nxt;
        logic ov_m;
        int ch_m;
        logic ld;
        logic [3:0] er;

        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // reset with all channels valid
        add(0, 4'hF, 16'hDCBA, 1, 4'b0000, 0, 4'h0, 0);
        add(0, 4'hF, 16'hDCBA, 1, 4'b0000, 0, 4'h0, 0);
        // round robin 0,1,2,3,0
        add(1, 4'hF, 16'hDCBA, 1, 4'b0001, 1, 4'hA, 0);
        add(1, 4'hF, 16'hDCBA, 1, 4'b0010, 1, 4'hB, 1);
        add(1, 4'hF, 16'hDCBA, 1, 4'b0100, 1, 4'hC, 2);
        add(1, 4'hF, 16'hDCBA, 1, 4'b1000, 1, 4'hD, 3);
        add(1, 4'hF, 16'hDCBA, 1, 4'b0001, 1, 4'hA, 0);
        // drain: valid drops, data/ch keep
        add(1, 4'h0, 16'h0000, 1, 4'b0000, 0, 4'hA, 0);
        // backpressure on channel 2
        add(1, 4'h4, 16'h0500, 0, 4'b0100, 1, 4'h5, 2);
        add(1, 4'h4, 16'h0500, 0, 4'b0000, 1, 4'h5, 2);
        add(1, 4'h4, 16'h0500, 0, 4'b0000, 1, 4'h5, 2);
        add(1, 4'h4, 16'h0500, 0, 4'b0000, 1, 4'h5, 2);
        add(1, 4'h4, 16'h0600, 1, 4'b0100, 1, 4'h6, 2);
        // wrap and skip: grant 3, then 1,3,1
        add(1, 4'h8, 16'h7000, 1, 4'b1000, 1, 4'h7, 3);
        add(1, 4'hA, 16'h3010, 1, 4'b0010, 1, 4'h1, 1);
        add(1, 4'hA, 16'h3010, 1, 4'b1000, 1, 4'h3, 3);
        add(1, 4'hA, 16'h3010, 1, 4'b0010, 1, 4'h1, 1);
        add(1, 4'h0, 16'h0000, 1, 4'b0000, 0, 4'h1, 1);
        // drop-out of channel 1 while channel 0 stalls
        add(1, 4'h3, 16'h0098, 0, 4'b0001, 1, 4'h8, 0);
        add(1, 4'h1, 16'h0008, 0, 4'b0000, 1, 4'h8, 0);
        add(1, 4'h1, 16'h0008, 0, 4'b0000, 1, 4'h8, 0);
        add(1, 4'h0, 16'h0000, 1, 4'b0000, 0, 4'h8, 0);
        add(1, 4'h6, 16'h0210, 1, 4'b0010, 1, 4'h1, 1);
        // mid-stream reset, priority restarts at 0
        add(1, 4'h6, 16'h0210, 0, 4'b0000, 1, 4'h1, 1);
        add(0, 4'h6, 16'h0210, 0, 4'b0000, 0, 4'h0, 0);
        add(1, 4'h6, 16'h0210, 1, 4'b0010, 1, 4'h1, 1);
        add(1, 4'h6, 16'h0210, 1, 4'b0100, 1, 4'h2, 2);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst_n         = vecs[i].rst;
            bus.in_valid  = vecs[i].v;
            bus.in_data   = vecs[i].d;
            bus.out_ready = vecs[i].ordy;
            #1;
            chk("in_ready", i, 32'(bus.in_ready), 32'(vecs[i].er));
            @(posedge clk);
            #1;
            chk("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].eov));
            chk("out_data", i, 32'(bus.out_data), 32'(vecs[i].eod));
            chk("out_ch", i, 32'(bus.out_ch), 32'(vecs[i].ech));
            @(negedge clk);
        end

        // Fairness under intermittent backpressure, all channels valid.
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 100, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nxt = 0;
        ov_m = 1'b0;
        ch_m = 0;
        for (int c = 0; c < 12; c++) begin
            bus.in_valid  = 4'hF;
            bus.in_data   = 16'hDCBA;
            bus.out_ready = (c % 3 != 0);
            #1;
            ld = !ov_m || bus.out_ready;
            er = ld ? 4'(1 << nxt) : 4'b0000;
            chk("fair_ready", 200 + c, 32'(bus.in_ready), 32'(er));
            @(posedge clk);
            #1;
            if (ld) begin
                ov_m = 1'b1;
                ch_m = nxt;
                nxt  = (nxt + 1) % 4;
            end
            chk("fair_valid", 200 + c, 32'(bus.out_valid), 32'(ov_m));
            chk("fair_ch", 200 + c, 32'(bus.out_ch), 32'(ch_m));
            chk("fair_data", 200 + c, 32'(bus.out_data), 32'(10 + ch_m));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
